// File: rtl/regfile_ctrl.sv
// regfile_ctrl: command sequencer for an 8 x 16-bit register file.
// Accepts one register-transfer/ALU command at a time on a valid/ready
// port. Walks the regfile read port through operand loads and drives the
// write port in EXEC. Keeps a {N,V,Z} status register that only CMP updates.
//
// Optional feature macro: REGFILE_CTRL_SHIFT_EN
//   defined   -> operand B is shifted by cmd_sh as it is captured in LOADB
//   undefined -> cmd_sh is ignored and B is the raw register value
module regfile_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rn,
  input  logic [2:0]  cmd_rm,
  input  logic [1:0]  cmd_sh,
  input  logic [7:0]  cmd_imm,
  output logic [2:0]  rf_readnum,
  input  logic [15:0] rf_data_out,
  output logic        rf_write,
  output logic [2:0]  rf_writenum,
  output logic [15:0] rf_data_in,
  output logic        done,
  output logic [2:0]  status
);

  // Opcode encodings; 110 and 111 are both treated as NOP.
  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_MVN  = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADA = 2'd1,
    LOADB = 2'd2,
    EXEC  = 2'd3
  } state_t;

  state_t      state;

  // Only the command fields still needed after the accept edge are held.
  // rn and imm are consumed on the accept edge itself (the LOADA read
  // address and the MOVI write data are registered there), so they need
  // no separate copy.
  logic [2:0]  op_q;
  logic [2:0]  rd_q;
  logic [2:0]  rm_q;

  // Operand registers. Both are loaded from the regfile before EXEC, so
  // every operand reflects the register contents from before the command.
  logic [15:0] a_q;
  logic [15:0] b_q;

  // Operand B as it will be captured at the end of LOADB.
  logic [15:0] b_next;

  // Write-back value for the writing ops. It is formed from the incoming
  // B so that it can be registered onto rf_data_in on the edge that
  // enters EXEC.
  logic [15:0] exec_result;

  // Compare path. It works from the registered A and B during EXEC.
  logic [15:0] cmp_diff;
  logic [2:0]  cmp_flags;

`ifdef REGFILE_CTRL_SHIFT_EN
  logic [1:0]  sh_q;

  // Shift operand B on its way into the B register.
  always_comb begin
    b_next = rf_data_out;
    case (sh_q)
      2'b01:   b_next = {rf_data_out[14:0], 1'b0};
      2'b10:   b_next = {1'b0, rf_data_out[15:1]};
      2'b11:   b_next = {rf_data_out[15], rf_data_out[15:1]};
      default: b_next = rf_data_out;
    endcase
  end
`else
  logic unused_sh;

  assign unused_sh = ^cmd_sh;
  assign b_next    = rf_data_out;
`endif

  // Select the write-back value for the command that is about to enter EXEC.
  always_comb begin
    exec_result = b_next;
    case (op_q)
      OP_MOV:  exec_result = b_next;
      OP_MVN:  exec_result = ~b_next;
      OP_ADD:  exec_result = a_q + b_next;
      OP_AND:  exec_result = a_q & b_next;
      default: exec_result = b_next;
    endcase
  end

  // Derive the {N,V,Z} flags of A - B. V is signed overflow: the operand
  // signs differ and the sign of the result differs from the sign of A.
  always_comb begin
    cmp_diff  = a_q - b_q;
    cmp_flags = {cmp_diff[15],
                 (a_q[15] != b_q[15]) && (cmp_diff[15] != a_q[15]),
                 cmp_diff == 16'h0000};
  end

  // Sequencer: the state and every output register are updated together.
  // Each regfile port value is registered on the edge that enters the
  // state that uses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      status      <= 3'b000;
      op_q        <= 3'd0;
      rd_q        <= 3'd0;
      rm_q        <= 3'd0;
`ifdef REGFILE_CTRL_SHIFT_EN
      sh_q        <= 2'd0;
`endif
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      rf_readnum  <= 3'd0;
      rf_write    <= 1'b0;
      rf_writenum <= 3'd0;
      rf_data_in  <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            rd_q <= cmd_rd;
            rm_q <= cmd_rm;
`ifdef REGFILE_CTRL_SHIFT_EN
            sh_q <= cmd_sh;
`endif
            case (cmd_op)
              OP_MOVI: begin
                state       <= EXEC;
                cmd_ready   <= 1'b0;
                rf_write    <= 1'b1;
                rf_writenum <= cmd_rd;
                rf_data_in  <= {{8{cmd_imm[7]}}, cmd_imm};
              end
              OP_MOV, OP_MVN: begin
                state      <= LOADB;
                cmd_ready  <= 1'b0;
                rf_readnum <= cmd_rm;
              end
              OP_ADD, OP_AND, OP_CMP: begin
                state      <= LOADA;
                cmd_ready  <= 1'b0;
                rf_readnum <= cmd_rn;
              end
              default: begin
                // A NOP completes on its accept edge and stays ready.
                done <= 1'b1;
              end
            endcase
          end
        end
        LOADA: begin
          a_q        <= rf_data_out;
          rf_readnum <= rm_q;
          state      <= LOADB;
        end
        LOADB: begin
          b_q        <= b_next;
          rf_readnum <= 3'd0;
          state      <= EXEC;
          if (op_q != OP_CMP) begin
            rf_write    <= 1'b1;
            rf_writenum <= rd_q;
            rf_data_in  <= exec_result;
          end
        end
        EXEC: begin
          if (op_q == OP_CMP) begin
            status <= cmp_flags;
          end
          rf_write    <= 1'b0;
          rf_writenum <= 3'd0;
          rf_data_in  <= 16'h0000;
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          done        <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: self-checking bench for regfile_ctrl. It owns a behavioural
// 8 x 16 register file wired to the controller. It checks directed scenarios
// and a randomized command stream against a reference model. The model works
// on whole commands from the pre-command register values.
// Honours REGFILE_CTRL_SHIFT_EN the same way as the design.
module tb_regfile_ctrl;

`ifdef REGFILE_CTRL_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op, cmd_rd, cmd_rn, cmd_rm;
  logic [1:0]  cmd_sh;
  logic [7:0]  cmd_imm;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;
  logic        rf_write;
  logic [2:0]  rf_writenum;
  logic [15:0] rf_data_in;
  logic        done;
  logic [2:0]  status;

  int checks = 0;
  int errors = 0;

  // Behavioural regfile and the observations collected from its ports.
  logic [15:0] rf_mem [8];
  int          write_count = 0;
  logic [2:0]  last_wnum;
  logic [15:0] last_wdata;
  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx;
  logic [15:0] pre_val;

  // Monitor results.
  int done_count = 0;
  int mon_errors = 0;

  // Reference model state.
  logic [15:0] ref_regs [8];
  logic [2:0]  ref_status;

  regfile_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rn      (cmd_rn),
    .cmd_rm      (cmd_rm),
    .cmd_sh      (cmd_sh),
    .cmd_imm     (cmd_imm),
    .rf_readnum  (rf_readnum),
    .rf_data_out (rf_data_out),
    .rf_write    (rf_write),
    .rf_writenum (rf_writenum),
    .rf_data_in  (rf_data_in),
    .done        (done),
    .status      (status)
  );

  always #5 clk = ~clk;

  assign rf_data_out = rf_mem[rf_readnum];

  // Regfile write port, plus a backdoor preload used only while the controller is idle.
  always @(posedge clk) begin
    if (rf_write === 1'b1) begin
      rf_mem[rf_writenum] = rf_data_in;
      write_count         = write_count + 1;
      last_wnum           = rf_writenum;
      last_wdata          = rf_data_in;
    end else if (pre_en) begin
      rf_mem[pre_idx] = pre_val;
    end
  end

  // While idle, the regfile ports must sit at zero; also count done pulses.
  always @(negedge clk) begin
    if (done === 1'b1) done_count = done_count + 1;
    if (cmd_ready === 1'b1 &&
        (rf_write !== 1'b0 || rf_readnum !== 3'd0 ||
         rf_writenum !== 3'd0 || rf_data_in !== 16'h0000)) begin
      mon_errors = mon_errors + 1;
      $display("[TB] FAIL idle_ports at %0t: write=%b readnum=%0d writenum=%0d data_in=%h, required all 0",
               $time, rf_write, rf_readnum, rf_writenum, rf_data_in);
    end
  end

  // Operand-B shift as arithmetic on the unsigned value.
  function automatic logic [15:0] shift_ref(input logic [15:0] v, input logic [1:0] sh);
    int x;
    x = int'(v);
    if (!SHIFT_EN) return v;
    case (sh)
      2'd1:    return 16'((x * 2) % 65536);
      2'd2:    return 16'(x / 2);
      2'd3:    return 16'(x / 2 + ((x >= 32768) ? 32768 : 0));
      default: return v;
    endcase
  endfunction

  // Whole-command reference: result, whether it writes, new flags, and latency.
  task automatic model_cmd(input logic [2:0] op, rn, rm, input logic [1:0] sh,
                           input logic [7:0] imm, output logic [15:0] res,
                           output logic wr, output logic [2:0] flags, output int lat);
    int a, b, sa, sb, sd, dd;
    a     = int'(ref_regs[rn]);
    b     = int'(shift_ref(ref_regs[rm], sh));
    res   = 16'h0000;
    wr    = 1'b0;
    flags = ref_status;
    case (op)
      3'd0: begin res = 16'((imm >= 8'd128) ? int'(imm) + 65280 : int'(imm)); wr = 1'b1; lat = 2; end
      3'd1: begin res = 16'(b); wr = 1'b1; lat = 3; end
      3'd2: begin res = 16'((a + b) % 65536); wr = 1'b1; lat = 4; end
      3'd3: begin res = 16'(a & b); wr = 1'b1; lat = 4; end
      3'd4: begin res = 16'(65535 - b); wr = 1'b1; lat = 3; end
      3'd5: begin
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        sd = sa - sb;
        dd = (a - b + 65536) % 65536;
        flags = {dd >= 32768, (sd > 32767) || (sd < -32768), dd == 0};
        lat = 4;
      end
      default: lat = 1;
    endcase
  endtask

  task automatic preload(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
    ref_regs[idx] = val;
  endtask

  // Wait for done, bounded; edges counts from the accept edge, -1 on timeout.
  task automatic wait_done(output int edges);
    edges = 1;
    @(negedge clk);
    while (done !== 1'b1 && edges < 12) begin
      @(posedge clk);
      edges = edges + 1;
      @(negedge clk);
    end
    if (done !== 1'b1) edges = -1;
  endtask

  // Issue one command and report its latency, the writes it made, and done one cycle later.
  task automatic run_cmd(input logic [2:0] op, rd, rn, rm, input logic [1:0] sh,
                         input logic [7:0] imm, output int edges, output int wdelta,
                         output logic done_after);
    int wc0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_sh = sh; cmd_imm = imm;
    wc0 = write_count;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op  = 3'($urandom); cmd_rd = 3'($urandom); cmd_rn = 3'($urandom);
    cmd_rm  = 3'($urandom); cmd_sh = 2'($urandom); cmd_imm = 8'($urandom);
    wait_done(edges);
    wdelta = write_count - wc0;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    #12;
    reset_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b need 1", cmd_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b need 0", done); end
    checks++; if (status !== 3'b000) begin errors++; $display("[TB] FAIL reset_status got %b need 000", status); end
    checks++;
    if ({rf_readnum, rf_write, rf_writenum, rf_data_in} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_rf_ports got rn=%0d w=%b wn=%0d d=%h need all 0",
               rf_readnum, rf_write, rf_writenum, rf_data_in);
    end
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    ref_status = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_movi();
    int e, w; logic da;
    run_cmd(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h02, e, w, da);
    checks++; if (e != 2) begin errors++; $display("[TB] FAIL movi_latency got %0d need 2", e); end
    checks++; if (w != 1) begin errors++; $display("[TB] FAIL movi_writes got %0d need 1", w); end
    checks++; if (last_wnum !== 3'd0 || last_wdata !== 16'h0002) begin
      errors++; $display("[TB] FAIL movi_r0 got r%0d=%h need r0=0002", last_wnum, last_wdata); end
    checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL movi_done_width got %b need 0", da); end
    ref_regs[0] = 16'h0002;
    run_cmd(3'd0, 3'd5, 3'd0, 3'd0, 2'd0, 8'h80, e, w, da);
    checks++; if (last_wnum !== 3'd5 || last_wdata !== 16'hFF80) begin
      errors++; $display("[TB] FAIL movi_sext got r%0d=%h need r5=ff80", last_wnum, last_wdata); end
    checks++; if (rf_mem[5] !== 16'hFF80) begin errors++; $display("[TB] FAIL movi_r5_stored got %h need ff80", rf_mem[5]); end
    ref_regs[5] = 16'hFF80;
  endtask

  task automatic test_add_cmp();
    int e, w; logic da;
    preload(3'd0, 16'h7FFF);
    preload(3'd1, 16'h0001);
    run_cmd(3'd2, 3'd2, 3'd0, 3'd1, 2'd0, 8'h00, e, w, da);
    checks++; if (e != 4) begin errors++; $display("[TB] FAIL add_latency got %0d need 4", e); end
    checks++; if (last_wnum !== 3'd2 || last_wdata !== 16'h8000) begin
      errors++; $display("[TB] FAIL add_result got r%0d=%h need r2=8000", last_wnum, last_wdata); end
    checks++; if (status !== 3'b000) begin errors++; $display("[TB] FAIL add_status got %b need 000", status); end
    ref_regs[2] = 16'h8000;
    run_cmd(3'd5, 3'd0, 3'd2, 3'd1, 2'd0, 8'h00, e, w, da);
    checks++; if (w != 0) begin errors++; $display("[TB] FAIL cmp_no_write got %0d writes need 0", w); end
    checks++; if (e != 4) begin errors++; $display("[TB] FAIL cmp_latency got %0d need 4", e); end
    checks++; if (status !== 3'b010) begin errors++; $display("[TB] FAIL cmp_overflow got %b need 010", status); end
    run_cmd(3'd5, 3'd0, 3'd1, 3'd1, 2'd0, 8'h00, e, w, da);
    checks++; if (status !== 3'b001) begin errors++; $display("[TB] FAIL cmp_equal got %b need 001", status); end
    ref_status = 3'b001;
  endtask

  task automatic test_back_to_back();
    int e1, e2, wc0;
    preload(3'd0, 16'h7FFF);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd1; cmd_rd = 3'd3; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_sh = 2'd0; cmd_imm = 8'h00;
    wc0 = write_count;
    @(posedge clk);
    #1;
    cmd_op = 3'd4; cmd_rd = 3'd4;
    wait_done(e1);
    checks++; if (e1 != 3) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d need 3", e1); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_in_done got %b need 1", cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(e2);
    checks++; if (e2 != 3) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d need 3", e2); end
    checks++; if (write_count - wc0 != 2) begin errors++; $display("[TB] FAIL b2b_writes got %0d need 2", write_count - wc0); end
    checks++; if (rf_mem[3] !== 16'h7FFF) begin errors++; $display("[TB] FAIL b2b_mov got %h need 7fff", rf_mem[3]); end
    checks++; if (rf_mem[4] !== 16'h8000) begin errors++; $display("[TB] FAIL b2b_mvn got %h need 8000", rf_mem[4]); end
    ref_regs[3] = 16'h7FFF;
    ref_regs[4] = 16'h8000;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_width got %b need 0", done); end
  endtask

  task automatic test_reset_mid_cmd();
    int wc0, dc0, e, w; logic da;
    preload(3'd2, 16'h1234);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd2; cmd_rd = 3'd2; cmd_rn = 3'd0; cmd_rm = 3'd1; cmd_sh = 2'd0;
    wc0 = write_count;
    dc0 = done_count;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || rf_write !== 1'b0 || rf_readnum !== 3'd0) begin
      errors++; $display("[TB] FAIL midreset_outputs got ready=%b done=%b w=%b rn=%0d need 1 0 0 0",
                         cmd_ready, done, rf_write, rf_readnum); end
    checks++; if (status !== 3'b000) begin errors++; $display("[TB] FAIL midreset_status got %b need 000", status); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (write_count != wc0) begin errors++; $display("[TB] FAIL midreset_no_write got %0d writes need 0", write_count - wc0); end
    checks++; if (done_count != dc0) begin errors++; $display("[TB] FAIL midreset_no_done got %0d dones need 0", done_count - dc0); end
    ref_status = 3'b000;
    run_cmd(3'd1, 3'd7, 3'd0, 3'd2, 2'd0, 8'h00, e, w, da);
    checks++; if (last_wdata !== 16'h1234 || rf_mem[2] !== 16'h1234) begin
      errors++; $display("[TB] FAIL midreset_readback got %h (r2=%h) need 1234", last_wdata, rf_mem[2]); end
    ref_regs[7] = 16'h1234;
  endtask

  task automatic test_shift();
    logic [15:0] expv [3];
    logic [1:0]  shv  [3];
    int e, w; logic da;
    shv[0] = 2'd3; shv[1] = 2'd2; shv[2] = 2'd1;
    if (SHIFT_EN) begin expv[0] = 16'hFFC0; expv[1] = 16'h7FC0; expv[2] = 16'hFF00; end
    else          begin expv[0] = 16'hFF80; expv[1] = 16'hFF80; expv[2] = 16'hFF80; end
    preload(3'd0, 16'hFF80);
    for (int i = 0; i < 3; i++) begin
      run_cmd(3'd1, 3'd6, 3'd0, 3'd0, shv[i], 8'h00, e, w, da);
      checks++; if (last_wdata !== expv[i]) begin
        errors++; $display("[TB] FAIL shift_sh%0d got %h need %h", shv[i], last_wdata, expv[i]); end
      ref_regs[6] = expv[i];
    end
  endtask

  task automatic test_random();
    logic [2:0] op, rd, rn, rm; logic [1:0] sh; logic [7:0] imm;
    logic [15:0] res; logic wr; logic [2:0] flags; int lat, e, w; logic da;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom); rd = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom);
      sh = 2'($urandom); imm = 8'($urandom);
      model_cmd(op, rn, rm, sh, imm, res, wr, flags, lat);
      run_cmd(op, rd, rn, rm, sh, imm, e, w, da);
      if (wr) ref_regs[rd] = res;
      ref_status = flags;
      checks++; if (e != lat) begin errors++; $display("[TB] FAIL rand%0d_latency op=%0d got %0d need %0d", n, op, e, lat); end
      checks++; if (w != (wr ? 1 : 0)) begin errors++; $display("[TB] FAIL rand%0d_writes op=%0d got %0d need %0d", n, op, w, wr); end
      checks++; if (status !== ref_status) begin errors++; $display("[TB] FAIL rand%0d_status op=%0d got %b need %b", n, op, status, ref_status); end
      checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_done_width got %b need 0", n, da); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rf_mem[i] !== ref_regs[i]) begin
          errors++; $display("[TB] FAIL rand%0d_r%0d op=%0d got %h need %h", n, i, op, rf_mem[i], ref_regs[i]);
        end
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_sh = 2'd0; cmd_imm = 8'h00;
    test_reset();
    test_movi();
    test_add_cmp();
    test_back_to_back();
    test_reset_mid_cmd();
    test_shift();
    test_random();
    checks++;
    if (mon_errors != 0) begin
      errors++;
      $display("[TB] FAIL idle_port_monitor got %0d violations need 0", mon_errors);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command sequencer for the 8 x 16-bit register file (one combinational read port, one clocked write port). It accepts one register-transfer/ALU command at a time on a valid/ready port. It drives the regfile read and write ports over a fixed per-opcode state sequence and keeps a 3-bit status register updated by compares. It sits between the instruction decoder and the regfile and is the only block allowed to drive `readnum`, `writenum`, `write` and `data_in`.

## Interface
- No parameters: 8 registers, 16-bit data, fixed.
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle; a command is accepted on the edge where valid & ready
- cmd_op  in  3  000 MOVI, 001 MOV, 010 ADD, 011 AND, 100 MVN, 101 CMP, 110/111 NOP
- cmd_rd, cmd_rn, cmd_rm  in  3 each  destination, operand A, operand B register numbers
- cmd_sh  in  2  operand-B shift select (see Configuration)
- cmd_imm  in  8  immediate for MOVI, sign-extended to 16 bits
- rf_readnum  out  3  to regfile readnum
- rf_data_out  in  16  from regfile data_out (combinational read of rf_readnum)
- rf_write  out  1  to regfile write
- rf_writenum  out  3  to regfile writenum
- rf_data_in  out  16  to regfile data_in
- done  out  1  one-cycle completion pulse
- status  out  3  {N, V, Z}, updated only by CMP

## Operation
- States: IDLE, LOADA, LOADB, EXEC. cmd_ready = 1 only in IDLE.
- On accept, op/rd/rn/rm/sh/imm are latched. Command inputs are ignored outside IDLE and may change freely.
- Sequences after accept:
  - MOVI: EXEC.
  - MOV, MVN: LOADB, EXEC.
  - ADD, AND, CMP: LOADA, LOADB, EXEC.
  - NOP: returns straight to IDLE with done.
- LOADA: rf_readnum = rn; A register captures rf_data_out at the end of the cycle.
- LOADB: rf_readnum = rm; B register captures the shifted rf_data_out at the end of the cycle.
- EXEC results:
  - MOVI: sext(imm).
  - MOV: B.
  - MVN: ~B.
  - ADD: A+B, mod 2^16, carry discarded.
  - AND: A&B.
- EXEC write behaviour: rf_write = 1, rf_writenum = rd, rf_data_in = result. The regfile stores the result on the closing edge.
- CMP in EXEC: rf_write = 0. status latches from D = A−B (mod 2^16):
  - Z = (D == 0)
  - N = D[15]
  - V = A[15] ≠ B[15] and D[15] ≠ A[15]
- Default outputs outside the states above: rf_readnum = 0, rf_write = 0, rf_writenum = 0, rf_data_in = 0.
- done is registered. It is high for exactly the one cycle following EXEC (or following the accept edge for NOP), coinciding with IDLE.
- Read-after-write needs no stall: a write lands on the EXEC closing edge, before any later LOADA/LOADB.

## Timing
- Reset values (immediate on reset_n low, independent of clk):
  - state IDLE, cmd_ready 1, done 0, status 000, A = B = 0.
  - All rf_* outputs 0.
- Reset mid-command: the command is dropped, no write occurs, no done is produced, and status is unchanged from its reset value.
- Latency, counted as edges from the accept edge to the start of the done cycle: NOP 1, MOVI 2, MOV/MVN 3, ADD/AND/CMP 4.
- Back-to-back: in the done cycle cmd_ready = 1. A command valid in that cycle is accepted on its closing edge, so there are zero bubbles between commands.
- rf_write is high for exactly one cycle per writing command. It is never high in IDLE, LOADA or LOADB.
- rd may equal rn and/or rm. Operands are always the pre-command register values.

## Configuration
- REGFILE_CTRL_SHIFT_EN defined: the LOADB capture applies cmd_sh to rf_data_out.
  - 00 none
  - 01 shift left 1, 0 in
  - 10 logical shift right 1, 0 in
  - 11 arithmetic shift right 1, bit 15 replicated
- REGFILE_CTRL_SHIFT_EN undefined: cmd_sh is ignored and B = rf_data_out unchanged. No other behaviour differs.

## Test plan
- Reset: drive reset_n low mid-cycle -> all outputs 0 and cmd_ready = 1 immediately; status = 000.
- MOVI r0, 0x02 -> one cycle with rf_write = 1, rf_writenum = 0, rf_data_in = 0x0002; done 2 edges after accept. MOVI r5, 0x80 -> rf_data_in = 0xFF80.
- r0 = 0x7FFF, r1 = 0x0001. ADD r2, r0, r1 -> rf_data_in = 0x8000 and done 4 edges after accept; status unchanged. CMP r2, r1 -> status {N,V,Z} = {0,1,0}. CMP r1, r1 -> {0,0,1}.
- Back-to-back with cmd_valid held high: MOV r3, r0 then MVN r4, r0 -> r3 = 0x7FFF, r4 = 0x8000. The second accept falls in the first done cycle, and no rf_write occurs outside EXEC.
- Reset during LOADB of an ADD -> rf_write never asserts, no done, r-destination keeps its old value (verified by a subsequent MOV readback).
- With REGFILE_CTRL_SHIFT_EN: r0 = 0xFF80, MOV r6, r0, sh = 11 -> 0xFFC0; sh = 10 -> 0x7FC0; sh = 01 -> 0xFF00. Without the macro, all three give 0xFF80.
